// File: rtl/uart_apb4_master.sv
// Byte-stream to APB4 bridge: parses 'W'/'R' command frames from a UART receiver,
// runs a single APB4 transfer, and streams the status byte (plus read data) back.
module uart_apb4_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] paddr_o,
  output logic [2:0]  pprot_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        busy_o
);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;
  localparam logic [7:0] RSP_TMO  = 8'h54;
  localparam logic [7:0] RSP_UNK  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_SETUP, S_ACCESS, S_RESP
  } state_t;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_is_read;
  logic          r_data_phase;
  logic [TW-1:0] r_tcnt;
  logic          r_rx_ready;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic [31:0]   r_paddr;
  logic          r_pwrite;
  logic [31:0]   r_pwdata;
  logic [3:0]    r_pstrb;
  logic          r_psel;
  logic          r_penable;

  logic          w_rx_fire;
  logic          w_tx_fire;
  logic          w_timeout;
  logic [1:0]    w_next_idx;
  logic [31:0]   w_addr_merged;
  logic [31:0]   w_wdata_merged;

  assign w_rx_fire  = rx_valid_i && r_rx_ready;
  assign w_tx_fire  = r_tx_valid && tx_ready_i;
  assign w_next_idx = r_idx + 2'd1;
  // Terminal count is the TIMEOUT-th ACCESS cycle without pready.
  assign w_timeout  = (TIMEOUT != 0) && !pready_i && (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_addr_merged  = r_addr;
    w_wdata_merged = r_wdata;
    w_addr_merged[{r_idx, 3'b000} +: 8]  = rx_data_i;
    w_wdata_merged[{r_idx, 3'b000} +: 8] = rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rdata      <= 32'd0;
      r_is_read    <= 1'b0;
      r_data_phase <= 1'b0;
      r_tcnt       <= '0;
      r_rx_ready   <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'd0;
      r_paddr      <= 32'd0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= 32'd0;
      r_pstrb      <= 4'd0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          r_idx      <= 2'd0;
          if (w_rx_fire) begin
            if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
              r_is_read <= (rx_data_i == OP_READ);
              r_state   <= S_ADDR;
            end else begin
              r_is_read    <= 1'b0;
              r_rx_ready   <= 1'b0;
              r_tx_valid   <= 1'b1;
              r_tx_data    <= RSP_UNK;
              r_data_phase <= 1'b0;
              r_state      <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= w_addr_merged;
            r_idx  <= w_next_idx;
            if (r_idx == 2'd3) begin
              r_idx <= 2'd0;
              if (!r_is_read) begin
                r_state <= S_WDATA;
              end else begin
                r_rx_ready <= 1'b0;
                r_paddr    <= w_addr_merged;
                r_pwrite   <= 1'b0;
                r_pstrb    <= 4'h0;
                r_psel     <= 1'b1;
                r_state    <= S_SETUP;
              end
            end
          end
        end
        S_WDATA: begin
          if (w_rx_fire) begin
            r_wdata <= w_wdata_merged;
            r_idx   <= w_next_idx;
            if (r_idx == 2'd3) begin
              r_idx      <= 2'd0;
              r_rx_ready <= 1'b0;
              r_paddr    <= r_addr;
              r_pwdata   <= w_wdata_merged;
              r_pwrite   <= 1'b1;
              r_pstrb    <= 4'hF;
              r_psel     <= 1'b1;
              r_state    <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_tcnt    <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready is checked first so it wins over a coincident terminal count.
          if (pready_i) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rdata      <= prdata_i;
            r_tx_data    <= pslverr_i ? RSP_ERR : RSP_OK;
            r_tx_valid   <= 1'b1;
            r_data_phase <= 1'b0;
            r_idx        <= 2'd0;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rdata      <= 32'd0;
            r_tx_data    <= RSP_TMO;
            r_tx_valid   <= 1'b1;
            r_data_phase <= 1'b0;
            r_idx        <= 2'd0;
            r_state      <= S_RESP;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_RESP: begin
          // Status byte first, then (reads only) four data bytes indexed by r_idx.
          if (w_tx_fire) begin
            if (!r_is_read || (r_data_phase && r_idx == 2'd3)) begin
              r_tx_valid   <= 1'b0;
              r_rx_ready   <= 1'b1;
              r_idx        <= 2'd0;
              r_data_phase <= 1'b0;
              r_state      <= S_IDLE;
            end else if (!r_data_phase) begin
              r_data_phase <= 1'b1;
              r_tx_data    <= r_rdata[7:0];
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= r_rdata[{w_next_idx, 3'b000} +: 8];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready_o = r_rx_ready;
  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign paddr_o    = r_paddr;
  assign pprot_o    = 3'b000;
  assign psel_o     = r_psel;
  assign penable_o  = r_penable;
  assign pwrite_o   = r_pwrite;
  assign pwdata_o   = r_pwdata;
  assign pstrb_o    = r_pstrb;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_apb4_master.sv
// Directed bench for uart_apb4_master: vector table of command frames plus
// hand-written sequences for handshake latency, tx back-pressure and mid-transfer reset.
module tb_uart_apb4_master;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  rx_data_i = 8'd0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i = 32'd0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;
  logic        busy_o;

  uart_apb4_master #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // APB slave model and monitor, evaluated mid-cycle.
  int          waits = 0;
  logic        stall = 1'b0;
  int          acc_k = 0;
  int          sel_cnt = 0;
  int          en_cnt = 0;
  int          stable_err = 0;
  logic [31:0] s_addr, s_wdata;
  logic        s_write;
  logic [3:0]  s_strb;

  always @(negedge clk_i) begin
    if (psel_o && penable_o) acc_k++;
    else acc_k = 0;
    pready_i = psel_o && penable_o && !stall && (acc_k > waits);
    if (psel_o) begin
      sel_cnt++;
      if (!penable_o) begin
        s_addr = paddr_o; s_wdata = pwdata_o; s_write = pwrite_o; s_strb = pstrb_o;
      end else if (paddr_o !== s_addr || pwdata_o !== s_wdata ||
                   pwrite_o !== s_write || pstrb_o !== s_strb) begin
        stable_err++;
      end
    end
    if (penable_o) en_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    int          nwait;
    logic        hang;
    int          nresp;
    logic [39:0] resp;
    int          esel;
    int          een;
    logic [3:0]  strb;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic slverr, input int nwait,
                              input logic hang, input int nresp, input logic [39:0] resp,
                              input int esel, input int een, input logic [3:0] strb);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.slverr = slverr;
    v.nwait = nwait; v.hang = hang; v.nresp = nresp; v.resp = resp;
    v.esel = esel; v.een = een; v.strb = strb;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (!rx_ready_o) begin
      total_cnt++;
      $display("FAIL rx_ready_wait: got 0 expected 1 within 60 cycles");
    end
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52)
      for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
    if (op == 8'h57)
      for (int k = 0; k < 4; k++) send_byte(wdata[8*k +: 8]);
  endtask

  task automatic recv_resp(input int n, output logic [39:0] got, output int ngot);
    got = 40'd0;
    ngot = 0;
    tx_ready_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!tx_valid_o && w < 100) begin
        @(negedge clk_i);
        w++;
      end
      if (!tx_valid_o) break;
      got[8*k +: 8] = tx_data_o;
      ngot++;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [39:0] got;
    int ngot;
    waits = v.nwait; stall = v.hang; prdata_i = v.rdata; pslverr_i = v.slverr;
    sel_cnt = 0; en_cnt = 0; stable_err = 0;
    send_frame(v.op, v.addr, v.wdata);
    recv_resp(v.nresp, got, ngot);
    $display("vec %0d: op=%h addr=%h resp=%h (%0d bytes) psel=%0d penable=%0d",
             id, v.op, v.addr, got, ngot, sel_cnt, en_cnt);
    chk($sformatf("v%0d_nresp", id), 64'(ngot), 64'(v.nresp));
    for (int k = 0; k < v.nresp; k++)
      chk($sformatf("v%0d_resp%0d", id, k), 64'(got[8*k +: 8]), 64'(v.resp[8*k +: 8]));
    chk($sformatf("v%0d_idle_txv", id), 64'(tx_valid_o), 64'd0);
    chk($sformatf("v%0d_idle_busy", id), 64'(busy_o), 64'd0);
    chk($sformatf("v%0d_idle_rxrdy", id), 64'(rx_ready_o), 64'd1);
    chk($sformatf("v%0d_psel_cycles", id), 64'(sel_cnt), 64'(v.esel));
    chk($sformatf("v%0d_penable_cycles", id), 64'(en_cnt), 64'(v.een));
    if (v.esel > 0) begin
      chk($sformatf("v%0d_paddr", id), 64'(s_addr), 64'(v.addr));
      chk($sformatf("v%0d_pwrite", id), 64'(s_write), 64'(v.op == 8'h57));
      chk($sformatf("v%0d_pstrb", id), 64'(s_strb), 64'(v.strb));
      chk($sformatf("v%0d_apb_stable", id), 64'(stable_err), 64'd0);
      if (v.op == 8'h57) chk($sformatf("v%0d_pwdata", id), 64'(s_wdata), 64'(v.wdata));
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [39:0] got;
    int ngot, n, hits;

    vecs[0] = mk(8'h57, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0, 1, 40'h4B, 2, 1, 4'hF);
    vecs[1] = mk(8'h52, 32'h4000_0004, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0, 5, {8'h12, 8'h34, 8'h56, 8'h78, 8'h4B}, 5, 4, 4'h0);
    vecs[2] = mk(8'h52, 32'h4000_0008, 32'h0, 32'hA5A5_A5A5, 1'b1, 0, 1'b0, 5, {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h45}, 2, 1, 4'h0);
    vecs[3] = mk(8'h52, 32'h4000_000C, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 5, {8'h00, 8'h00, 8'h00, 8'h00, 8'h54}, 9, 8, 4'h0);
    vecs[4] = mk(8'h57, 32'h4000_0020, 32'h0102_0304, 32'h0, 1'b0, 0, 1'b0, 1, 40'h4B, 2, 1, 4'hF);
    vecs[5] = mk(8'h33, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1, 40'h3F, 0, 0, 4'h0);
    vecs[6] = mk(8'h57, 32'h1234_5678, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1'b0, 1, 40'h4B, 3, 2, 4'hF);

    // Reset state and first rx_ready after release.
    #3;
    chk("rst_psel", 64'(psel_o), 64'd0);
    chk("rst_penable", 64'(penable_o), 64'd0);
    chk("rst_txvalid", 64'(tx_valid_o), 64'd0);
    chk("rst_rxready", 64'(rx_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_paddr_pstrb", 64'({paddr_o, pstrb_o, pprot_o}), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("rel_rxready_before_edge", 64'(rx_ready_o), 64'd0);
    @(negedge clk_i);
    chk("rel_rxready_after_edge", 64'(rx_ready_o), 64'd1);
    $display("reset: rx_ready=%0d busy=%0d", rx_ready_o, busy_o);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Exact latency and tx back-pressure on a write status byte.
    waits = 0; stall = 1'b0; pslverr_i = 1'b0;
    tx_ready_i = 1'b0;
    send_frame(8'h57, 32'h4000_0040, 32'h5555_AAAA);
    chk("lat_setup_psel", 64'({psel_o, penable_o}), 64'b10);
    @(posedge clk_i); #1;
    chk("lat_access", 64'({psel_o, penable_o}), 64'b11);
    @(posedge clk_i); #1;
    chk("lat_status_valid", 64'({tx_valid_o, psel_o, penable_o}), 64'b100);
    chk("lat_status_byte", 64'(tx_data_o), 64'h4B);
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (tx_valid_o === 1'b1 && tx_data_o === 8'h4B && rx_ready_o === 1'b0) hits++;
    end
    chk("stall_hold_cycles", 64'(hits), 64'd5);
    tx_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("stall_release_rxready", 64'(rx_ready_o), 64'd1);
    chk("stall_release_txvalid", 64'(tx_valid_o), 64'd0);
    $display("stall: held 4B for %0d cycles, rx_ready=%0d after handshake", hits, rx_ready_o);

    // Reset asserted in ACCESS: outputs drop without a clock edge, no late response.
    stall = 1'b1;
    send_frame(8'h52, 32'h4000_0050, 32'h0);
    n = 0;
    while (!penable_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("mid_reset_in_access", 64'(penable_o), 64'd1);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("mid_reset_apb", 64'({psel_o, penable_o}), 64'b00);
    chk("mid_reset_tx", 64'({tx_valid_o, busy_o, rx_ready_o}), 64'b000);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    stall = 1'b0;
    hits = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (tx_valid_o === 1'b1 || psel_o === 1'b1) hits++;
    end
    chk("mid_reset_no_response", 64'(hits), 64'd0);
    $display("mid-reset: stray activity cycles=%0d", hits);
    run_vec(7, vecs[0]);

    // Unused variables for the unused recv path keep the block tidy.
    got = 40'd0; ngot = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
